uart_rx_bit_timer: RTL and testbench

//  Parametrised oversampling bit timer for the UART receiver. Counts oversample edges per bit and

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_majority3.sv | 59 +++++
 rtl/uart_rx_bit_timer.sv | 139 +++++++++++++
 tb/tb_uart_rx_bit_timer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART receive-path constants and helpers. Used by the bit timer, the
// majority voter and the Rx FSM.
//   UART_PRESC_MIN  smallest usable oversampling ratio (three samples + vote)
//   UART_FRAME_MIN  smallest usable frame length in bits
//   SMP_EARLY/MID/LATE  positions of the three mid-bit samples in the 3-bit
//                       sample shift register (oldest sample in the MSB)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_PRESC_MIN = 4;
    localparam int UART_FRAME_MIN = 2;

    localparam int SMP_EARLY = 2;
    localparam int SMP_MID   = 1;
    localparam int SMP_LATE  = 0;

    // 2-of-3 majority over the three mid-bit samples
    function automatic logic maj3(input logic [2:0] smp);
        return (smp[SMP_EARLY] & smp[SMP_MID])
             | (smp[SMP_EARLY] & smp[SMP_LATE])
             | (smp[SMP_MID]   & smp[SMP_LATE]);
    endfunction

endpackage

// File: rtl/uart_majority3.sv
// ---------------------------------------------------------------------------
// uart_majority3
// Three-sample shift register with a registered 2-of-3 vote.
//   CLK, RST     clock, asynchronous active-low reset
//   clear        synchronous clear of samples and valid (vote_bit holds)
//   sample_en    shift sample_in into the sample register
//   sample_in    serial line value to sample
//   vote_en      this cycle carries the last sample; vote over it next edge
//   vote_bit     registered majority result, resets to 1 (idle line)
//   vote_valid   registered 1-cycle pulse: vote_bit was just updated
// ---------------------------------------------------------------------------
module uart_majority3
    import uart_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic sample_en,
    input  logic sample_in,
    input  logic vote_en,
    output logic vote_bit,
    output logic vote_valid
);

    logic [2:0] smp_r;
    logic       vote_bit_r;
    logic       vote_valid_r;
    logic [2:0] smp_next_s;

    // Sample register contents after this cycle's shift; the vote uses it so
    // the late sample counts without an extra cycle of latency.
    always_comb begin
        smp_next_s = {smp_r[SMP_MID], smp_r[SMP_LATE], sample_in};
    end

    // Sample shift register and registered vote
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            smp_r        <= 3'b000;
            vote_bit_r   <= 1'b1;
            vote_valid_r <= 1'b0;
        end else if (clear) begin
            smp_r        <= 3'b000;
            vote_valid_r <= 1'b0;
        end else begin
            if (sample_en) begin
                smp_r <= smp_next_s;
            end
            if (vote_en) begin
                vote_bit_r <= maj3(smp_next_s);
            end
            vote_valid_r <= vote_en;
        end
    end

    assign vote_bit   = vote_bit_r;
    assign vote_valid = vote_valid_r;

endmodule

// File: rtl/uart_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_timer
// Oversampling bit timer for the UART receiver: counts oversample edges per
// bit and bits per frame, strobes three mid-bit samples and majority-votes
// the line over them.
//   CLK, RST      clock, asynchronous active-low reset
//   Count_En      run counters; low clears counters and samples next cycle
//   Prescale      oversample edges per bit (latched at start, min 4)
//   Frame_Len     bits per frame incl. start/parity/stop (latched, min 2)
//   Rx_In         synchronised serial line
//   Edge_Cnt      edge within bit, 1..Prescale_q (0 when idle)
//   Bit_Cnt       bit within frame, 0..Frame_Len_q-1
//   Sample_Stb    high on the three mid-bit sample edges
//   Sampled_Bit   majority of the last three samples (1 after reset)
//   Sample_Valid  1-cycle pulse: Sampled_Bit updated
//   Bit_Done      1-cycle pulse: last edge of a bit
//   Frame_Done    1-cycle pulse: last edge of the last bit of the frame
//   Start_Err     1-cycle pulse with Sample_Valid: start bit voted as 1
// ---------------------------------------------------------------------------
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int PRESC_W  = 8,
    parameter int BITCNT_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Count_En,
    input  logic [PRESC_W-1:0]  Prescale,
    input  logic [BITCNT_W-1:0] Frame_Len,
    input  logic                Rx_In,
    output logic [PRESC_W-1:0]  Edge_Cnt,
    output logic [BITCNT_W-1:0] Bit_Cnt,
    output logic                Sample_Stb,
    output logic                Sampled_Bit,
    output logic                Sample_Valid,
    output logic                Bit_Done,
    output logic                Frame_Done,
    output logic                Start_Err
);

    logic [PRESC_W-1:0]  edge_cnt_r;
    logic [BITCNT_W-1:0] bit_cnt_r;
    logic [PRESC_W-1:0]  presc_q_r;
    logic [BITCNT_W-1:0] flen_q_r;
    logic                start_tag_r;

    logic [PRESC_W-1:0]  presc_clamp_s;
    logic [BITCNT_W-1:0] flen_clamp_s;
    logic [PRESC_W-1:0]  mid_s;
    logic                active_s;
    logic                bit_done_s;
    logic                last_bit_s;
    logic                strobe_s;
    logic                vote_en_s;
    logic                vote_bit_s;
    logic                vote_valid_s;

    // Clamp the frame parameters to the smallest values the timer can honour
    always_comb begin
        if (Prescale < PRESC_W'(UART_PRESC_MIN)) begin
            presc_clamp_s = PRESC_W'(UART_PRESC_MIN);
        end else begin
            presc_clamp_s = Prescale;
        end
        if (Frame_Len < BITCNT_W'(UART_FRAME_MIN)) begin
            flen_clamp_s = BITCNT_W'(UART_FRAME_MIN);
        end else begin
            flen_clamp_s = Frame_Len;
        end
    end

    // Event decode from the registered counters. Edge_Cnt==0 is the idle or
    // latch cycle, where the latched values may still be stale, so nothing
    // is decoded there.
    always_comb begin
        mid_s      = presc_q_r >> 1;
        active_s   = Count_En & (edge_cnt_r != PRESC_W'(0));
        bit_done_s = active_s & (edge_cnt_r == presc_q_r);
        last_bit_s = (bit_cnt_r == (flen_q_r - BITCNT_W'(1)));
        strobe_s   = active_s & ((edge_cnt_r == (mid_s - PRESC_W'(1)))
                               | (edge_cnt_r == mid_s)
                               | (edge_cnt_r == (mid_s + PRESC_W'(1))));
        vote_en_s  = active_s & (edge_cnt_r == (mid_s + PRESC_W'(1)));
    end

    // Edge/bit counters, parameter latching and start-bit tag for the vote
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_r  <= PRESC_W'(0);
            bit_cnt_r   <= BITCNT_W'(0);
            presc_q_r   <= PRESC_W'(0);
            flen_q_r    <= BITCNT_W'(0);
            start_tag_r <= 1'b0;
        end else if (!Count_En) begin
            edge_cnt_r  <= PRESC_W'(0);
            bit_cnt_r   <= BITCNT_W'(0);
            start_tag_r <= 1'b0;
        end else begin
            start_tag_r <= vote_en_s & (bit_cnt_r == BITCNT_W'(0));
            if (edge_cnt_r == PRESC_W'(0)) begin
                edge_cnt_r <= PRESC_W'(1);
                presc_q_r  <= presc_clamp_s;
                flen_q_r   <= flen_clamp_s;
            end else if (bit_done_s) begin
                edge_cnt_r <= PRESC_W'(1);
                if (last_bit_s) begin
                    bit_cnt_r <= BITCNT_W'(0);
                end else begin
                    bit_cnt_r <= bit_cnt_r + BITCNT_W'(1);
                end
            end else begin
                edge_cnt_r <= edge_cnt_r + PRESC_W'(1);
            end
        end
    end

    uart_majority3 u_majority3 (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (~Count_En),
        .sample_en  (strobe_s),
        .sample_in  (Rx_In),
        .vote_en    (vote_en_s),
        .vote_bit   (vote_bit_s),
        .vote_valid (vote_valid_s)
    );

    assign Edge_Cnt     = edge_cnt_r;
    assign Bit_Cnt      = bit_cnt_r;
    assign Sample_Stb   = strobe_s;
    assign Sampled_Bit  = vote_bit_s;
    // A vote in flight is dropped if the Rx FSM disables counting
    assign Sample_Valid = Count_En & vote_valid_s;
    assign Start_Err    = Count_En & vote_valid_s & start_tag_r & vote_bit_s;
    assign Bit_Done     = bit_done_s;
    assign Frame_Done   = bit_done_s & last_bit_s;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_bit_timer
// Scoreboard bench: each driven cycle pushes the expected outputs for that
// cycle (from a closed-form edge/bit model), the monitor pops and compares
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_bit_timer;

    localparam int PW = 8;
    localparam int BW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Count_En;
    logic [PW-1:0] Prescale;
    logic [BW-1:0] Frame_Len;
    logic          Rx_In;
    logic [PW-1:0] Edge_Cnt;
    logic [BW-1:0] Bit_Cnt;
    logic          Sample_Stb;
    logic          Sampled_Bit;
    logic          Sample_Valid;
    logic          Bit_Done;
    logic          Frame_Done;
    logic          Start_Err;

    uart_rx_bit_timer #(.PRESC_W(PW), .BITCNT_W(BW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Count_En     (Count_En),
        .Prescale     (Prescale),
        .Frame_Len    (Frame_Len),
        .Rx_In        (Rx_In),
        .Edge_Cnt     (Edge_Cnt),
        .Bit_Cnt      (Bit_Cnt),
        .Sample_Stb   (Sample_Stb),
        .Sampled_Bit  (Sampled_Bit),
        .Sample_Valid (Sample_Valid),
        .Bit_Done     (Bit_Done),
        .Frame_Done   (Frame_Done),
        .Start_Err    (Start_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [PW-1:0] edge_v;
        logic [BW-1:0] bit_v;
        logic          stb;
        logic          valid;
        logic          sbit;
        logic          bdone;
        logic          fdone;
        logic          serr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    int n_cmp = 0;
    int n_err = 0;
    int serr_seen = 0;
    int fdone_seen = 0;
    int sv_seen = 0;

    // reference model state
    int          cnt;
    int          m_p;
    int          m_f;
    logic        vote_prev;
    logic        vote_val;
    logic        vote_start;
    logic        exp_sbit;
    logic [2:0]  smp;
    logic [15:0] frame_word;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // line value for a given bit/edge under a stimulus mode
    function automatic logic rx_for(input int mode, input int b, input int e);
        case (mode)
            0:       return frame_word[b];
            1:       return (b == 0) ? (e == 4) : frame_word[b];
            2:       return (b == 0) ? (e == 3 || e == 4) : frame_word[b];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // monitor: compare DUT outputs with the expected entry for this cycle
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            check_val("edge_cnt", 32'(Edge_Cnt), 32'(mon_x.edge_v));
            check_val("bit_cnt", 32'(Bit_Cnt), 32'(mon_x.bit_v));
            check_val("sample_stb", 32'(Sample_Stb), 32'(mon_x.stb));
            check_val("sample_valid", 32'(Sample_Valid), 32'(mon_x.valid));
            check_val("sampled_bit", 32'(Sampled_Bit), 32'(mon_x.sbit));
            check_val("bit_done", 32'(Bit_Done), 32'(mon_x.bdone));
            check_val("frame_done", 32'(Frame_Done), 32'(mon_x.fdone));
            check_val("start_err", 32'(Start_Err), 32'(mon_x.serr));
            if (Start_Err === 1'b1) serr_seen++;
            if (Frame_Done === 1'b1) fdone_seen++;
            if (Sample_Valid === 1'b1) sv_seen++;
        end
    end

    // drive one clock cycle and push its expected outputs
    task automatic cyc(input logic en_v, input int mode, input logic rst_v);
        exp_t x;
        int   e;
        int   b;
        int   m;
        logic rx;
        logic act;
        x = '0;
        if (!rst_v) begin
            RST       = 1'b0;
            Count_En  = en_v;
            Rx_In     = 1'b1;
            cnt       = 0;
            vote_prev = 1'b0;
            exp_sbit  = 1'b1;
            x.sbit    = 1'b1;
            sb_q.push_back(x);
        end else begin
            RST = 1'b1;
            if (en_v && cnt == 0) begin
                m_p = (Prescale < 8'd4) ? 4 : int'(Prescale);
                m_f = (Frame_Len < 4'd2) ? 2 : int'(Frame_Len);
            end
            if (cnt == 0) begin
                e = 0;
                b = 0;
            end else begin
                e = (cnt - 1) % m_p + 1;
                b = ((cnt - 1) / m_p) % m_f;
            end
            m  = m_p / 2;
            rx = (e == 0) ? 1'b1 : rx_for(mode, b, e);
            Count_En = en_v;
            Rx_In    = rx;
            act = en_v && (cnt > 0);
            if (vote_prev) exp_sbit = vote_val;
            x.edge_v = e[PW-1:0];
            x.bit_v  = b[BW-1:0];
            x.stb    = act && (e == m - 1 || e == m || e == m + 1);
            x.bdone  = act && (e == m_p);
            x.fdone  = x.bdone && (b == m_f - 1);
            x.valid  = en_v && vote_prev;
            x.sbit   = exp_sbit;
            x.serr   = x.valid && vote_start && vote_val;
            sb_q.push_back(x);
            if (act && e >= m - 1 && e <= m + 1) smp[e - (m - 1)] = rx;
            vote_prev = act && (e == m + 1);
            if (vote_prev) begin
                vote_val   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
                vote_start = (b == 0);
            end
            cnt = en_v ? cnt + 1 : 0;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int s0;
        int f0;
        int v0;
        RST        = 1'b0;
        Count_En   = 1'b0;
        Rx_In      = 1'b1;
        Prescale   = 8'd8;
        Frame_Len  = 4'd10;
        frame_word = 16'h02D6;
        cnt = 0; m_p = 4; m_f = 2;
        vote_prev = 1'b0; vote_val = 1'b1; vote_start = 1'b0;
        exp_sbit = 1'b1; smp = 3'b000;
        @(posedge CLK);
        #1;

        // reset and idle
        repeat (3) cyc(1'b0, 0, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b1);

        // nominal 8x oversampling, 10-bit frames, into a second frame
        f0 = fdone_seen;
        repeat (90) cyc(1'b1, 0, 1'b1);
        check_val("nominal_frame_done_count", 32'(fdone_seen - f0), 32'd1);
        cyc(1'b0, 0, 1'b1);

        // single-sample glitch on the start bit is voted out
        s0 = serr_seen;
        repeat (8) cyc(1'b1, 1, 1'b1);
        check_val("glitch_sampled_bit", 32'(Sampled_Bit), 32'd0);
        repeat (4) cyc(1'b1, 1, 1'b1);
        check_val("glitch_no_start_err", 32'(serr_seen - s0), 32'd0);
        cyc(1'b0, 0, 1'b1);

        // two-sample high start bit flags a false start
        s0 = serr_seen;
        repeat (10) cyc(1'b1, 2, 1'b1);
        check_val("false_start_count", 32'(serr_seen - s0), 32'd1);
        cyc(1'b0, 0, 1'b1);

        // clamped parameters: 4 edges per bit, 2 bits per frame
        Prescale  = 8'd2;
        Frame_Len = 4'd1;
        f0 = fdone_seen;
        repeat (25) cyc(1'b1, 3, 1'b1);
        check_val("clamp_frame_done_count", 32'(fdone_seen - f0), 32'd3);
        cyc(1'b0, 0, 1'b1);

        // prescale change is ignored until the timer is restarted
        Prescale  = 8'd8;
        Frame_Len = 4'd10;
        repeat (20) cyc(1'b1, 3, 1'b1);
        Prescale = 8'd16;
        repeat (20) cyc(1'b1, 3, 1'b1);
        cyc(1'b0, 3, 1'b1);
        repeat (40) cyc(1'b1, 3, 1'b1);
        cyc(1'b0, 0, 1'b1);

        // enable dropped on the last sample edge: vote discarded
        Prescale = 8'd8;
        repeat (5) cyc(1'b1, 0, 1'b1);
        v0 = sv_seen;
        cyc(1'b0, 0, 1'b1);
        repeat (3) cyc(1'b1, 0, 1'b1);
        check_val("drop_no_sample_valid", 32'(sv_seen - v0), 32'd0);
        check_val("drop_reenable_edge", 32'(Edge_Cnt), 32'd3);

        // asynchronous reset mid-frame, then clean restart
        repeat (6) cyc(1'b1, 3, 1'b1);
        cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 0, 1'b0);
        repeat (12) cyc(1'b1, 3, 1'b1);
        cyc(1'b0, 0, 1'b1);

        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
